// File: rtl/sha_mem_pkg.sv
// sha_mem_pkg: shared types and constants for the SHA engine word-memory responder.
package sha_mem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [15:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_FIN
    } seq_state_e;

    // SHA-256 initial hash values, the reference point for digest words.
    localparam word_t SHA_H_INIT [8] = '{
        32'h6a09_e667, 32'hbb67_ae85, 32'h3c6e_f372, 32'ha54f_f53a,
        32'h510e_527f, 32'h9b05_688c, 32'h1f83_d9ab, 32'h5be0_cd19
    };

endpackage

// File: rtl/sha_mem_sram.sv
// sha_mem_sram: single-port word array with a registered, write-first read port.
// Addresses at or beyond DEPTH never write and read back as zero.
module sha_mem_sram
    import sha_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    word_t         mem [DEPTH];
    logic          in_range;
    logic [AW-1:0] idx;
    word_t         rdata_q;
    word_t         rdata_d;

    assign in_range = ({1'b0, addr} < 17'(DEPTH));
    assign idx      = addr[AW-1:0];

    // Array contents are deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (in_range) begin
            rdata_d = we ? wdata : mem[idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sha_mem_responder.sv
// sha_mem_responder: word memory shared by a host port and the SHA engine, plus run sequencer.
// Define SHA_MEM_OOR_ERR_EN to add the sticky out-of-range flag output oor_err.
module sha_mem_responder
    import sha_mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_rvalid,
    output logic [31:0] host_rdata,
    input  logic        run,
    output logic        busy,
    output logic        run_done,
    output logic        run_err,
    output logic [31:0] cycles
`ifdef SHA_MEM_OOR_ERR_EN
    ,
    output logic        oor_err
`endif
);

    function automatic word_t sat_inc(input word_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    seq_state_e state_q, state_d;
    logic       eng_start_q, eng_start_d;
    logic       busy_q, busy_d;
    logic       run_done_q, run_done_d;
    logic       run_err_q, run_err_d;
    logic       host_rvalid_q, host_rvalid_d;
    word_t      cycles_q, cycles_d;
    word_t      tmo_q, tmo_d;

    logic       host_acc;
    logic       run_acc;
    logic       sram_we;
    addr_t      sram_addr;
    word_t      sram_wdata;
    word_t      sram_rdata;

    assign host_acc = host_valid && !busy_q;
    assign run_acc  = run && (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        run_err_d = run_err_q;
        cycles_d  = cycles_q;
        tmo_d     = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (run_acc) begin
                    state_d   = S_START;
                    run_err_d = 1'b0;
                    cycles_d  = '0;
                    tmo_d     = '0;
                end
            end
            S_START: begin
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                cycles_d = sat_inc(cycles_q);
                if (!eng_done) begin
                    state_d = S_WAIT_HI;
                end else if (tmo_q == 32'(TIMEOUT - 1)) begin
                    state_d   = S_FIN;
                    run_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            S_WAIT_HI: begin
                cycles_d = sat_inc(cycles_q);
                if (eng_done) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they leave the flop aligned with it.
        eng_start_d   = (state_d == S_START);
        busy_d        = (state_d != S_IDLE);
        run_done_d    = (state_d == S_FIN);
        host_rvalid_d = host_acc && !host_we;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            eng_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            run_done_q    <= 1'b0;
            run_err_q     <= 1'b0;
            host_rvalid_q <= 1'b0;
            cycles_q      <= '0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            eng_start_q   <= eng_start_d;
            busy_q        <= busy_d;
            run_done_q    <= run_done_d;
            run_err_q     <= run_err_d;
            host_rvalid_q <= host_rvalid_d;
            cycles_q      <= cycles_d;
            tmo_q         <= tmo_d;
        end
    end

    // Engine owns the array while busy; when idle the host wins, otherwise reads follow mem_addr.
    always_comb begin
        sram_we    = 1'b0;
        sram_addr  = mem_addr;
        sram_wdata = mem_write_data;
        if (busy_q) begin
            sram_we = mem_we;
        end else if (host_acc) begin
            sram_we    = host_we;
            sram_addr  = host_addr;
            sram_wdata = host_wdata;
        end
    end

    sha_mem_sram #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (sram_we),
        .addr    (sram_addr),
        .wdata   (sram_wdata),
        .rdata   (sram_rdata)
    );

`ifdef SHA_MEM_OOR_ERR_EN
    logic oor_err_q, oor_err_d;
    logic addr_oor;

    assign addr_oor = ({1'b0, sram_addr} >= 17'(DEPTH));

    always_comb begin
        oor_err_d = oor_err_q;
        if (run_acc) begin
            oor_err_d = 1'b0;
        end
        if ((busy_q || host_acc) && addr_oor) begin
            oor_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_err_q <= 1'b0;
        end else begin
            oor_err_q <= oor_err_d;
        end
    end

    assign oor_err = oor_err_q;
`endif

    assign mem_read_data = sram_rdata;
    assign host_rdata    = sram_rdata;
    assign eng_start     = eng_start_q;
    assign busy          = busy_q;
    assign host_ready    = !busy_q;
    assign host_rvalid   = host_rvalid_q;
    assign run_done      = run_done_q;
    assign run_err       = run_err_q;
    assign cycles        = cycles_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// tb_sha_mem_responder: directed plus randomized checks of sha_mem_responder against a
// behavioural memory model and an in-bench engine stub.
module tb_sha_mem_responder;
    import sha_mem_pkg::*;

    localparam int DEPTH   = 256;
    localparam int TIMEOUT = 16;
    localparam int NWORDS  = 20;

    logic        clk;
    logic        reset_n;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        eng_start;
    logic        eng_done;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        run;
    logic        busy;
    logic        run_done;
    logic        run_err;
    logic [31:0] cycles;
`ifdef SHA_MEM_OOR_ERR_EN
    logic        oor_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] model [DEPTH];
    int          wq [$];

    sha_mem_responder #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .eng_start      (eng_start),
        .eng_done       (eng_done),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .run            (run),
        .busy           (busy),
        .run_done       (run_done),
        .run_err        (run_err),
        .cycles         (cycles)
`ifdef SHA_MEM_OOR_ERR_EN
        ,
        .oor_err        (oor_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Toy engine digest: mixes the message into each SHA-256 initial value.
    function automatic logic [31:0] digest_word(input logic [31:0] w [NWORDS], input int j);
        logic [31:0] acc;
        acc = SHA_H_INIT[j];
        for (int i = 0; i < NWORDS; i++) begin
            acc = {acc[26:0], acc[31:27]} + (w[i] ^ 32'(i * j + 1));
        end
        return acc;
    endfunction

    task automatic host_req(input logic we, input logic [15:0] a, input logic [31:0] d,
                            output int stall);
        @(posedge clk);
        #1;
        host_valid = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = d;
        stall      = 0;
        while (host_ready !== 1'b1 && stall < 200) begin
            @(posedge clk);
            #1;
            stall++;
        end
        if (stall >= 200) checkb("host_ready_wait", host_ready, 1'b1);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
        int st;
        host_req(1'b0, a, 32'h0, st);
        @(negedge clk);
        checkb({tag, "_rvalid"}, host_rvalid, 1'b1);
        check({tag, "_rdata"}, host_rdata, exp);
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        int st;
        host_req(1'b1, a, d, st);
        if (a < 16'(DEPTH)) begin
            model[a[7:0]] = d;
            wq.push_back(int'(a));
        end
    endtask

    task automatic tick(inout int lat, inout int meas);
        @(negedge clk);
        lat++;
        if (busy === 1'b1 && run_done !== 1'b1) meas++;
    endtask

    // Launches a run and plays the engine: digest_mode reads the message and writes
    // eight digest words at out_base; otherwise eng_done stays high to force a timeout.
    task automatic do_run(input bit digest_mode, input logic [15:0] out_base);
        logic [31:0] msg [NWORDS];
        logic [31:0] dg [8];
        int lat;
        int meas;
        @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        @(negedge clk);
        lat  = 1;
        meas = 0;
        checkb("start_pulse", eng_start, 1'b1);
        checkb("start_busy", busy, 1'b1);
        checkb("start_err_clr", run_err, 1'b0);
        check("start_cycles_clr", cycles, 32'h0);
        if (digest_mode) begin
            eng_done = 1'b0;
            for (int i = 0; i < NWORDS; i++) begin
                mem_addr = 16'(i);
                tick(lat, meas);
                msg[i] = mem_read_data;
            end
            for (int j = 0; j < 8; j++) dg[j] = digest_word(msg, j);
            for (int j = 0; j < 8; j++) begin
                mem_we         = 1'b1;
                mem_addr       = out_base + 16'(j);
                mem_write_data = dg[j];
                tick(lat, meas);
            end
            mem_we   = 1'b0;
            mem_addr = out_base + 16'd7;
            tick(lat, meas);
            check("eng_wr_then_rd", mem_read_data, dg[7]);
            checkb("eng_start_once", eng_start, 1'b0);
            eng_done = 1'b1;
        end
        for (int k = 0; k < TIMEOUT + 40 && run_done !== 1'b1; k++) tick(lat, meas);
        checkb("run_done_seen", run_done, 1'b1);
        if (!digest_mode) begin
            check("timeout_latency", 32'(lat), 32'(TIMEOUT + 2));
            check("timeout_cycles", cycles, 32'(TIMEOUT));
        end
        check("cycles_count", cycles, 32'(meas));
        checkb("run_err_state", run_err, !digest_mode);
        checkb("fin_busy", busy, 1'b1);
        @(negedge clk);
        checkb("post_busy", busy, 1'b0);
        checkb("done_one_cycle", run_done, 1'b0);
        check("cycles_hold", cycles, 32'(meas));
    endtask

    initial begin
        logic [31:0] arr [NWORDS];
        logic [31:0] dref [8];
        logic [15:0] a;
        logic [31:0] d;
        int          st;

        reset_n        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        eng_done       = 1'b1;
        host_valid     = 1'b0;
        host_we        = 1'b0;
        host_addr      = '0;
        host_wdata     = '0;
        run            = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_eng_start", eng_start, 1'b0);
        checkb("rst_run_done", run_done, 1'b0);
        checkb("rst_run_err", run_err, 1'b0);
        checkb("rst_rvalid", host_rvalid, 1'b0);
        check("rst_cycles", cycles, 32'h0);
        check("rst_mem_rd", mem_read_data, 32'h0);
`ifdef SHA_MEM_OOR_ERR_EN
        checkb("rst_oor", oor_err, 1'b0);
`endif
        reset_n = 1'b1;

        // Basic host write and read-back with single-cycle rvalid.
        host_write(16'd5, 32'h1111_1111);
        host_read(16'd5, 32'h1111_1111, "h5");
        @(negedge clk);
        checkb("h5_rvalid_drop", host_rvalid, 1'b0);

        // Engine write while idle is dropped, but its read still tracks mem_addr.
        mem_we         = 1'b1;
        mem_addr       = 16'd5;
        mem_write_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("idle_eng_rd", mem_read_data, model[5]);
        mem_we   = 1'b0;
        mem_addr = '0;
        host_read(16'd5, 32'h1111_1111, "idle_wr_drop");

        // Load a random message and run the engine.
        for (int i = 0; i < NWORDS; i++) host_write(16'(i), $urandom);
        for (int i = 0; i < NWORDS; i++) arr[i] = model[i];
        for (int j = 0; j < 8; j++) dref[j] = digest_word(arr, j);
        do_run(1'b1, 16'd100);
        for (int j = 0; j < 8; j++) begin
            host_read(16'(100 + j), dref[j], "digest1");
            model[100 + j] = dref[j];
            wq.push_back(100 + j);
        end

        // Engine never drops eng_done: timeout.
        do_run(1'b0, 16'd0);
        checkb("timeout_err_sticky", run_err, 1'b1);

        // Host request during a run stalls until the sequencer is idle again.
        @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        checkb("err_clr_on_run", run_err, 1'b0);
        host_req(1'b1, 16'd30, 32'hCAFE_0030, st);
        model[30] = 32'hCAFE_0030;
        wq.push_back(30);
        check("stall_cycles", 32'(st), 32'(TIMEOUT + 1));
        checkb("stall_run_err", run_err, 1'b1);
        host_read(16'd30, 32'hCAFE_0030, "stalled_wr");

        // Out-of-range addresses: dropped writes, zero reads, no aliasing.
        host_write(16'd256, 32'h5555_AAAA);
        host_read(16'd256, 32'h0, "oor256");
        host_write(16'd261, 32'h7777_7777);
        host_read(16'd5, model[5], "no_alias");
        host_write(16'd255, 32'h0BAD_F00D);
        host_read(16'd255, 32'h0BAD_F00D, "top_word");
`ifdef SHA_MEM_OOR_ERR_EN
        checkb("oor_set", oor_err, 1'b1);
`endif

        // Random host traffic against the model.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(256, 65535))
                                                : 16'($urandom_range(20, 255));
                d = $urandom;
                host_write(a, d);
            end else if ($urandom_range(0, 3) == 0) begin
                a = 16'($urandom_range(256, 65535));
                host_read(a, 32'h0, "rnd_oor_rd");
            end else begin
                a = 16'(wq[$urandom_range(0, wq.size() - 1)]);
                host_read(a, model[a[7:0]], "rnd_rd");
            end
        end

        // Second run with a fresh message also clears the timeout flag.
        for (int i = 0; i < NWORDS; i++) host_write(16'(i), $urandom);
        for (int i = 0; i < NWORDS; i++) arr[i] = model[i];
        for (int j = 0; j < 8; j++) dref[j] = digest_word(arr, j);
        do_run(1'b1, 16'd200);
`ifdef SHA_MEM_OOR_ERR_EN
        checkb("oor_clr", oor_err, 1'b0);
`endif
        for (int j = 0; j < 8; j++) host_read(16'(200 + j), dref[j], "digest2");

        // Reset while the engine holds eng_done low; array survives.
        host_write(16'd5, 32'h1111_1111);
        @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        @(negedge clk);
        eng_done = 1'b0;
        repeat (3) @(negedge clk);
        checkb("pre_rst_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkb("mid_rst_busy", busy, 1'b0);
        checkb("mid_rst_start", eng_start, 1'b0);
        checkb("mid_rst_done", run_done, 1'b0);
        check("mid_rst_cycles", cycles, 32'h0);
        check("mid_rst_mem_rd", mem_read_data, 32'h0);
        @(negedge clk);
        reset_n  = 1'b1;
        eng_done = 1'b1;
        host_read(16'd5, 32'h1111_1111, "post_rst_h5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
